// File: rtl/button_debouncer.sv
// Multi-channel input debouncer: synchroniser, shared sample prescaler,
// per-channel stability counters with registered edge pulses.
module button_debouncer #(
  parameter int PortWidth    = 4,
  parameter int CounterWidth = 16,
  parameter int StableCount  = 3,
  parameter int SyncStages   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [PortWidth-1:0] in,
  output logic [PortWidth-1:0] out,
  output logic [PortWidth-1:0] rise,
  output logic [PortWidth-1:0] fall,
  output logic                 tick
);

  localparam int SW = $clog2(StableCount + 1);
  localparam logic [SW-1:0] LAST = SW'(StableCount - 1);

  logic [SyncStages-1:0][PortWidth-1:0] sync_q, sync_d;
  logic [CounterWidth-1:0]              presc_q, presc_d;
  logic [PortWidth-1:0][SW-1:0]         cnt_q, cnt_d;
  logic [PortWidth-1:0]                 out_q, out_d;
  logic [PortWidth-1:0]                 rise_q, rise_d;
  logic [PortWidth-1:0]                 fall_q, fall_d;
  logic [PortWidth-1:0]                 sync_in;

  assign sync_in = sync_q[SyncStages-1];
  assign tick    = &presc_q;
  assign out     = out_q;
  assign rise    = rise_q;
  assign fall    = fall_q;

  always_comb begin
    sync_d[0] = in;
    for (int i = 1; i < SyncStages; i++) begin
      sync_d[i] = sync_q[i-1];
    end
    presc_d = presc_q + 1'b1;
    cnt_d   = cnt_q;
    out_d   = out_q;
    rise_d  = '0;
    fall_d  = '0;
    if (tick) begin
      for (int ch = 0; ch < PortWidth; ch++) begin
        if (sync_in[ch] == out_q[ch]) begin
          cnt_d[ch] = '0;
        end else if (cnt_q[ch] == LAST) begin
          // Enough consecutive differing samples: commit the new level.
          out_d[ch]  = sync_in[ch];
          cnt_d[ch]  = '0;
          rise_d[ch] = sync_in[ch];
          fall_d[ch] = ~sync_in[ch];
        end else begin
          cnt_d[ch] = cnt_q[ch] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= '0;
      presc_q <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
    end else begin
      sync_q  <= sync_d;
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

endmodule

// File: tb/tb_button_debouncer.sv
// Randomised scoreboard bench for button_debouncer against a
// sample-level reference model (CounterWidth=2, StableCount=3).
module tb_button_debouncer;

  localparam int PW = 4;
  localparam int CW = 2;
  localparam int SC = 3;
  localparam int SS = 2;
  localparam int M  = 1 << CW;

  logic          clk = 1'b0;
  logic          rst_r;
  logic [PW-1:0] in_r;
  logic [PW-1:0] out, rise, fall;
  logic          tick;

  int n_checks = 0;
  int n_pass   = 0;

  logic [3*PW:0] exp_q[$];

  button_debouncer #(
    .PortWidth   (PW),
    .CounterWidth(CW),
    .StableCount (SC),
    .SyncStages  (SS)
  ) dut (
    .clk (clk),
    .rst (rst_r),
    .in  (in_r),
    .out (out),
    .rise(rise),
    .fall(fall),
    .tick(tick)
  );

  always #5 clk = ~clk;

  // Reference model: inputs reach the sampler SS clocks late; a sample is
  // taken every M-th cycle after reset; a level is accepted once SC
  // consecutive samples disagree with the current output.
  initial begin
    logic [PW-1:0] hist[$];
    int            cyc;
    int            run[PW];
    logic [PW-1:0] m_out;
    logic [PW-1:0] r, f, sin;
    cyc   = 0;
    m_out = '0;
    forever begin
      @(posedge clk);
      r = '0;
      f = '0;
      if (rst_r) begin
        hist.delete();
        for (int k = 0; k < SS; k++) hist.push_back('0);
        cyc   = 0;
        m_out = '0;
        for (int ch = 0; ch < PW; ch++) run[ch] = 0;
      end else begin
        sin = hist[0];
        if (cyc % M == M - 1) begin
          for (int ch = 0; ch < PW; ch++) begin
            if (sin[ch] != m_out[ch]) begin
              run[ch]++;
              if (run[ch] == SC) begin
                m_out[ch] = sin[ch];
                r[ch]     = sin[ch];
                f[ch]     = ~sin[ch];
                run[ch]   = 0;
              end
            end else begin
              run[ch] = 0;
            end
          end
        end
        void'(hist.pop_front());
        hist.push_back(in_r);
        cyc++;
      end
      exp_q.push_back({m_out, r, f, (cyc % M == M - 1)});
    end
  end

  initial begin
    logic [3*PW:0] e, got;
    @(posedge clk);
    forever begin
      @(negedge clk);
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL scoreboard_empty at %0t: got no expectation", $time);
      end else begin
        e   = exp_q.pop_front();
        got = {out, rise, fall, tick};
        if (got === e)
          n_pass++;
        else
          $display("FAIL outputs at %0t: got out=%b rise=%b fall=%b tick=%b, need out=%b rise=%b fall=%b tick=%b",
                   $time, got[3*PW:2*PW+1], got[2*PW:PW+1], got[PW:1],
                   got[0], e[3*PW:2*PW+1], e[2*PW:PW+1], e[PW:1], e[0]);
      end
    end
  end

  task automatic step(input logic [PW-1:0] v, input logic r, input int n);
    repeat (n) begin
      in_r  = v;
      rst_r = r;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [PW-1:0] cur;
    in_r  = '0;
    rst_r = 1'b1;
    step(4'b0000, 1'b1, 3);
    step(4'b0000, 1'b0, 20);
    step(4'b0001, 1'b0, 20);
    step(4'b0011, 1'b0, 6);
    step(4'b0001, 1'b0, 20);
    step(4'b1101, 1'b0, 20);
    step(4'b1001, 1'b0, 20);
    step(4'b0000, 1'b0, 24);
    step(4'b0001, 1'b0, 11);
    step(4'b0001, 1'b1, 1);
    step(4'b0001, 1'b0, 20);
    for (int k = 0; k < 25; k++) begin
      step(4'b0001 ^ PW'(k % 2), 1'b0, 4);
    end
    step(4'b0000, 1'b0, 3);
    for (int k = 0; k < 25; k++) begin
      step(PW'(k % 2), 1'b0, 4);
    end
    cur = '0;
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 5) == 0)
        cur[$urandom_range(0, PW - 1)] ^= 1'b1;
      step(cur, ($urandom_range(0, 299) == 0), 1);
    end
    for (int k = 0; k < 40; k++) begin
      cur = PW'($urandom);
      step(cur, 1'b0, $urandom_range(1, 30));
    end
    step(cur, 1'b0, 4);
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
